// File: rtl/if_fetch_queue_pkg.sv
// Shared widths, reset constants and the fetch-queue entry layout for the
// instruction-fetch front end.
package if_fetch_queue_pkg;

    localparam int unsigned InstAddrWidth   = 32;
    localparam int unsigned InstWidth       = 32;
    localparam int unsigned FetchEntryWidth = InstAddrWidth + InstWidth;

    localparam logic [InstAddrWidth-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [InstAddrWidth-1:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [InstAddrWidth-1:0] pc;
        logic [InstWidth-1:0]     inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; low two bits are discarded.
    function automatic logic [InstAddrWidth-1:0] align_pc(input logic [InstAddrWidth-1:0] pc);
        return {pc[InstAddrWidth-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO with flush, count, full/empty and an unregistered head
// that reads zero while empty.
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = FetchEntryWidth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign count_o = count_q;

    // A push into a full queue is only accepted when a pop frees the slot.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues ROM reads and queues
// {pc, inst} pairs for decode; branch redirects flush and reload the PC.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned              DEPTH    = 4,
    parameter logic [InstAddrWidth-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [InstAddrWidth-1:0] rom_inst_addr_o,
    output logic                     rom_inst_en_o,
    input  logic [InstWidth-1:0]     rom_inst_i,
    input  logic                     redirect_i,
    input  logic [InstAddrWidth-1:0] redirect_pc_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [InstAddrWidth-1:0] id_pc_o,
    output logic [InstWidth-1:0]     id_inst_o
);

    logic [InstAddrWidth-1:0] pc_q, pc_d;
    logic                     fire, pop;
    logic                     fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]   unused_count;
    fetch_entry_t             push_entry, head_entry;

    assign id_valid_o = ~rst & ~fifo_empty;
    assign pop        = id_valid_o & id_ready_i;
    assign fire       = ~rst & ~redirect_i & (~fifo_full | pop);

    assign rom_inst_addr_o = pc_q;
    assign rom_inst_en_o   = fire;

    assign push_entry.pc   = pc_q;
    assign push_entry.inst = rom_inst_i;
    assign id_pc_o         = head_entry.pc;
    assign id_inst_o       = head_entry.inst;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FetchEntryWidth)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i),
        .push_i      (fire),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .head_data_o (head_entry),
        .count_o     (unused_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        pc_d = pc_q;
        if (redirect_i)  pc_d = align_pc(redirect_pc_i);
        else if (fire)   pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue with a combinational ROM
// returning the bitwise inverse of the fetch address.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] rom_inst_addr;
    logic        rom_inst_en;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h1c00_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rom_inst_addr_o (rom_inst_addr),
        .rom_inst_en_o   (rom_inst_en),
        .rom_inst_i      (rom_inst),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    assign rom_inst = rom_inst_addr ^ 32'hffff_ffff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // Advance past the next rising edge; inputs are driven here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_inst"}, id_inst, pc ^ 32'hffff_ffff);
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = ready;
        tick(); tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;

        // Reset state and streaming with decode always ready
        tick(); settle();
        check("rst_en", {31'b0, rom_inst_en}, 32'd0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_addr", rom_inst_addr, 32'h1c00_0000);
        check("rst_idpc", id_pc, 32'd0);
        check("rst_idinst", id_inst, 32'd0);
        tick();
        rst = 1'b0; settle();
        check("rel_en", {31'b0, rom_inst_en}, 32'd1);
        check("rel_valid", {31'b0, id_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check_head($sformatf("stream%0d", i), 32'h1c00_0000 + 32'(4 * i));
            check($sformatf("stream%0d_en", i), {31'b0, rom_inst_en}, 32'd1);
        end

        // Decode stalled: fill to four entries, then fetch stops
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill%0d_en", i), {31'b0, rom_inst_en}, 32'd1);
            check($sformatf("fill%0d_addr", i), rom_inst_addr, 32'h1c00_0000 + 32'(4 * i));
            tick(); settle();
        end
        for (int i = 0; i < 2; i++) begin
            check("full_en", {31'b0, rom_inst_en}, 32'd0);
            check("full_addr", rom_inst_addr, 32'h1c00_0010);
            check_head("full_head", 32'h1c00_0000);
            tick(); settle();
        end

        // One-cycle ready while full: pop and push together
        id_ready = 1'b1; settle();
        check("popush_en", {31'b0, rom_inst_en}, 32'd1);
        check("popush_addr", rom_inst_addr, 32'h1c00_0010);
        tick();
        id_ready = 1'b0; settle();
        check("popush_stillfull_en", {31'b0, rom_inst_en}, 32'd0);
        check("popush_pc", rom_inst_addr, 32'h1c00_0014);
        check_head("popush_head", 32'h1c00_0004);
        id_ready = 1'b1; settle();
        for (int i = 0; i < 5; i++) begin
            check_head($sformatf("drain%0d", i), 32'h1c00_0004 + 32'(4 * i));
            tick(); settle();
        end

        // Redirect with three entries queued
        do_reset(1'b0);
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h1c00_0103; settle();
        check("redir_en", {31'b0, rom_inst_en}, 32'd0);
        check("redir_valid_same", {31'b0, id_valid}, 32'd1);
        tick();
        redirect = 1'b0; settle();
        check("redir_valid_next", {31'b0, id_valid}, 32'd0);
        check("redir_addr", rom_inst_addr, 32'h1c00_0100);
        check("redir_en_next", {31'b0, rom_inst_en}, 32'd1);
        tick(); settle();
        check_head("redir_head", 32'h1c00_0100);

        // Redirect held three cycles: last target wins
        id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h2000_0000; settle();
        check("hold_a_en", {31'b0, rom_inst_en}, 32'd0);
        tick();
        redirect_pc = 32'h3000_0004; settle();
        check("hold_b_en", {31'b0, rom_inst_en}, 32'd0);
        check("hold_b_valid", {31'b0, id_valid}, 32'd0);
        tick();
        redirect_pc = 32'h4000_000a; settle();
        check("hold_c_en", {31'b0, rom_inst_en}, 32'd0);
        tick();
        redirect = 1'b0; settle();
        check("hold_resume_addr", rom_inst_addr, 32'h4000_0008);
        check("hold_resume_en", {31'b0, rom_inst_en}, 32'd1);
        tick(); settle();
        check_head("hold_head0", 32'h4000_0008);
        tick(); settle();
        check_head("hold_head1", 32'h4000_000c);

        // Reset together with redirect mid-stream: reset wins
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h5000_0000; settle();
        check("rstredir_en", {31'b0, rom_inst_en}, 32'd0);
        check("rstredir_valid", {31'b0, id_valid}, 32'd0);
        tick();
        rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; settle();
        check("rstredir_addr", rom_inst_addr, 32'h1c00_0000);
        check("rstredir_valid_after", {31'b0, id_valid}, 32'd0);
        check("rstredir_idpc", id_pc, 32'd0);

        // PC wrap at the top of the address space
        id_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hffff_ffff;
        tick();
        redirect = 1'b0; settle();
        check("wrap_addr0", rom_inst_addr, 32'hffff_fffc);
        tick(); settle();
        check("wrap_addr1", rom_inst_addr, 32'h0000_0000);
        check_head("wrap_head0", 32'hffff_fffc);
        tick(); settle();
        check_head("wrap_head1", 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end between the instruction ROM and the decode stage.
- Owns the program counter and drives the ROM address/enable. The ROM answers combinationally in the same cycle.
- Captures each {pc, inst} pair into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles branch redirects from the back end by flushing the queue and reloading the PC.

Parameters:
- DEPTH, 4, fetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h1c00_0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- rom_inst_addr_o  output  32  ROM fetch address; always equals the PC register.
- rom_inst_en_o  output  1  ROM read enable; high in every cycle a fetch is issued.
- rom_inst_i  input  32  ROM data for rom_inst_addr_o, valid in the same cycle.
- redirect_i  input  1  branch/jump taken; flush and restart fetch.
- redirect_pc_i  input  32  new PC; bits [1:0] are ignored and treated as 2'b00.
- id_valid_o  output  1  queue head is valid.
- id_ready_i  input  1  decode accepts the head this cycle.
- id_pc_o  output  32  PC of head entry.
- id_inst_o  output  32  instruction of head entry.

Behaviour:
- One clock domain: clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; queue emptied (count=0, read and write pointers 0).
  - While rst=1, rom_inst_en_o=0 and id_valid_o=0.
  - id_pc_o and id_inst_o read 0 while the queue is empty.
  - rst overrides redirect_i and the handshake.
- pop = id_valid_o & id_ready_i.
- fire (fetch issue) = !rst & !redirect_i & (count < DEPTH | pop). rom_inst_en_o = fire, combinational.
- On fire:
  - Push {pc, rom_inst_i} at the write pointer.
  - pc <= pc + 4, mod 2^32; wrap from 32'hffff_fffc to 0 is legal.
- On pop: advance the read pointer.
- Count update:
  - fire only: count+1.
  - pop only: count-1.
  - fire and pop: count unchanged.
- Push when full is allowed only in the same cycle as a pop; the pop frees the slot. No overflow, ever.
- id_valid_o = (count != 0). id_pc_o and id_inst_o come from the head entry directly (no output register). Latency from fetch to valid at decode is 1 cycle.
- Redirect (redirect_i=1, rst=0):
  - Queue flushed to empty; pc <= {redirect_pc_i[31:2], 2'b00}.
  - No fetch that cycle. A concurrent pop is still reported as completed: id_valid_o is unaffected in that cycle, and decode owns the consequence.
  - Next cycle: fetch resumes at the new PC; id_valid_o=0 that cycle; first valid output the cycle after.
- Back-to-back redirects: the last one wins; fetch stays stalled while redirect_i is held.
- Stability: while id_valid_o=1 and id_ready_i=0, id_pc_o and id_inst_o hold stable (absent redirect or rst).
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Steady state with id_ready_i=1 always: one instruction per cycle, sequential PCs, queue occupancy stays at 1.

Decomposition:
- Shared define file:
  - InstAddrWidth (31:0) and InstWidth (31:0) width macros.
  - RESET_PC default constant.
  - PC increment constant 4.
- Sub-module fetch_fifo: parameterised synchronous FIFO with push, pop, flush, count, full/empty, and head data, for width 64 ({pc, inst}).
- if_fetch_queue keeps only the PC register, fire logic and redirect handling.

Test Plan:
- Reset release, id_ready_i=1, ROM returns addr^32'hffff_ffff → rom_inst_en_o rises the first cycle after rst drops. Decode sees pc 1c000000, 1c000004, 1c000008 on consecutive cycles with matching inst values.
- id_ready_i=0 from reset release → exactly 4 fetches, then rom_inst_en_o=0 and the PC holds at 1c000010. Head stays pc=1c000000. Raising ready drains in order and fetch restarts the same cycle.
- Queue full, id_ready_i=1 for one cycle → simultaneous pop and push; count stays 4; next fetch pc=1c000010; no entry lost or duplicated.
- redirect_i=1 with redirect_pc_i=32'h1c00_0103 while 3 entries are queued → next cycle id_valid_o=0 and rom_inst_addr_o=1c000100. The following cycle the head pc is 1c000100.
- Redirect held 3 cycles (targets A, B, C) → no fetch during those cycles; fetch resumes at C.
- rst asserted mid-stream together with redirect_i → after the edge the queue is empty, pc=1c000000, and the redirect is ignored.
- pc=32'hffff_fffc fetch → next fetch addr 32'h0000_0000.
